dp_issue: RTL and testbench
===========================

# dp_issue

Data-processing issue unit that sits in front of the combinational ALU. It accepts one ARM-style data-processing instruction per handshake, evaluates its condition field against an internal NZCV flag register, and drives the ALU opcode, operands and carry inputs. It then samples the ALU result and `nzvc` outputs, performs register write-back, and updates the flags.

## Interface
Parameters:
- none (widths fixed at 32-bit datapath, 4-bit register address).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset; one clock, reset is asynchronous and active-low.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: unit can accept; high exactly while in IDLE.
- `instr` in 32: `[31:28]` cond, `[24:21]` opcode, `[20]` S, `[15:12]` Rd.
- `rn_data` in 32: first operand, sampled at accept.
- `op2_data` in 32: already-shifted second operand, sampled at accept.
- `shift_c` in 1: shifter carry-out, sampled at accept.
- `alu_src1`, `alu_src2` out 32: ALU operands (registered).
- `alu_ctrl` out 4: ALU opcode (registered).
- `alu_carry` out 1: current C flag, fed to the ALU carry input.
- `alu_shc` out 1: shifter-carry input to the ALU.
- `alu_result` in 32: ALU result.
- `alu_nzvc` in 4: ALU flags as N, Z, V, C in bits `[3:0]`.
- `wb_en` out 1: one-cycle register write strobe.
- `wb_addr` out 4: destination register.
- `wb_data` out 32: write-back data.
- `flags` out 4: NZVC register in the same bit order as `alu_nzvc`.
- `done` out 1: one-cycle pulse when an instruction retires, whether executed or skipped.

## Operation
- **ALU opcode encoding:** PLUS=0, cPLUS=1, MINUS=2, revMINUS=3, cMINUS=4, revcMINUS=5, MULT=6, AND=7, XOR=8, OR=9, NOT=10, CLEAR=11, RRX=12, MOVE=13, ALU_IDLE=15.
- **Opcode map:**
  - AND→AND, EOR→XOR, SUB→MINUS, RSB→revMINUS, ADD→PLUS, ADC→cPLUS, SBC→cMINUS, RSC→revcMINUS.
  - TST→AND, TEQ→XOR, CMP→MINUS, CMN→PLUS.
  - ORR→OR, MOV→MOVE, BIC→CLEAR, MVN→NOT.
- **Operand routing:**
  - Default: `alu_src1`=rn, `alu_src2`=op2.
  - MVN: `alu_src1`=op2, because ALU NOT inverts src1.
- **Shifter carry:** `alu_shc` = captured `shift_c` for logical ops (AND EOR TST TEQ ORR MOV BIC MVN); 0 for arithmetic ops.
- **Condition evaluation:** all 15 ARM conditions (EQ…AL); cond 1111 is treated as never.
- **FSM states:** IDLE, COND, EXEC, WB, SKIP.
  - IDLE: on `instr_valid`, capture `instr`, `rn_data`, `op2_data`, `shift_c` → COND.
  - COND: condition pass → EXEC, loading `alu_ctrl`/`alu_src1`/`alu_src2`; condition fail → SKIP.
  - EXEC: hold ALU inputs one settle cycle → WB.
  - WB:
    - Sample `alu_result`/`alu_nzvc`.
    - `wb_en`=1 unless TST/TEQ/CMP/CMN.
    - Pulse `done`.
    - → IDLE, with `alu_ctrl` returning to ALU_IDLE.
  - SKIP: pulse `done`, no write-back, flags unchanged → IDLE.
- **Flag update (at WB):**
  - Arithmetic ops with S, plus CMP/CMN always: flags ← `alu_nzvc`.
  - Logical ops with S, plus TST/TEQ always: N, Z, C ← `alu_nzvc`; V kept.
  - S=0 on non-compare ops: flags unchanged.
- **ALU_IDLE rule:** `alu_ctrl` sits at ALU_IDLE outside EXEC/WB. The ALU only re-evaluates on an opcode change, so this guarantees recomputation for back-to-back identical opcodes.
- **Rd:** Rd=15 gets no special handling.

## Timing
- Accept at edge 0 (valid & ready). COND runs cycle 1, EXEC cycle 2, WB cycle 3.
- `wb_en`/`done` are high during cycle 3; `instr_ready` rises in cycle 4. Throughput is one instruction per 4 cycles.
- A skipped instruction asserts `done` in cycle 2 and re-enters IDLE in cycle 3.
- `flags` reflect the update from cycle 4 onward. An instruction accepted in cycle 4 evaluates its condition against the new flags.
- `instr_valid` while not IDLE is ignored; no capture takes place.
- **Reset values:**
  - State IDLE; `flags`=0.
  - `alu_ctrl`=4'hF.
  - `alu_src1`, `alu_src2`, `wb_data`, `wb_addr` = 0.
  - `wb_en`, `done`, `alu_shc` = 0.
  - `instr_ready`=1.
- **Reset mid-operation:** reset asserted in any state aborts the instruction: no write-back, no flag change, and outputs take their reset values immediately.

## Structure
- **Shared package `dp_pkg`:**
  - ALU opcode enum, in ALU order, plus `ALU_IDLE`=4'hF.
  - ARM data-processing opcode enum.
  - Condition-code enum.
  - FSM state enum.
  - Flag bit index constants N=3, Z=2, V=1, C=0.
- **Sub-module:** one combinational `cond_check` (cond, flags → pass).

## Test plan
- **Overflow on ADDS:** reset, then ADDS R1 (`0xE0901000`), rn=0x7FFFFFFF, op2=1 → `alu_ctrl`=0 in EXEC; `wb_addr`=1, `wb_data`=0x80000000; `flags`=4'b1010.
- **Compare equal:** CMP (`0xE1500000`), rn=5, op2=5 → `wb_en` never high; `flags`=4'b0101; `done` in cycle 3.
- **Condition fail:** with Z=1, MOVNE R2 (`0x11A02000`) → `done` in cycle 2; `wb_en`=0; `alu_ctrl` stays 4'hF; `flags` unchanged.
- **Back-to-back identical opcodes:** two ADD R3 (`0xE0803000`), first rn=1/op2=2, then rn=10/op2=20 → `wb_data` 3 then 30.
- **ADC with carry:** with C=1, ADC R4 (`0xE0A04000`), rn=1, op2=1 → `alu_carry`=1; `wb_data`=3.
- **Reset during EXEC:** drive `rst_n` low in EXEC → `wb_en`/`done` never assert; `flags`=0; `alu_ctrl`=4'hF; `instr_ready`=1 after release.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types for the data-processing issue unit: ALU/ARM opcodes, conditions,
// FSM states, flag bit positions and the opcode decode helpers.
package dp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned FLAG_W = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [3:0] {
        ALU_PLUS      = 4'd0,
        ALU_CPLUS     = 4'd1,
        ALU_MINUS     = 4'd2,
        ALU_REVMINUS  = 4'd3,
        ALU_CMINUS    = 4'd4,
        ALU_REVCMINUS = 4'd5,
        ALU_MULT      = 4'd6,
        ALU_AND       = 4'd7,
        ALU_XOR       = 4'd8,
        ALU_OR        = 4'd9,
        ALU_NOT       = 4'd10,
        ALU_CLEAR     = 4'd11,
        ALU_RRX       = 4'd12,
        ALU_MOVE      = 4'd13,
        ALU_IDLE      = 4'd15
    } alu_op_e;

    typedef enum logic [3:0] {
        OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
        OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
    } dp_op_e;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_COND, ST_EXEC, ST_WB, ST_SKIP
    } state_e;

    // Fields of an accepted instruction that the unit actually uses.
    typedef struct packed {
        cond_e             cond;
        dp_op_e            op;
        logic              s;
        logic [REG_AW-1:0] rd;
    } dp_uop_t;

    function automatic logic is_logical(input dp_op_e op);
        return op inside {OP_AND, OP_EOR, OP_TST, OP_TEQ, OP_ORR, OP_MOV, OP_BIC, OP_MVN};
    endfunction

    function automatic logic is_compare(input dp_op_e op);
        return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
    endfunction

    function automatic alu_op_e alu_map(input dp_op_e op);
        alu_op_e r;
        case (op)
            OP_AND, OP_TST: r = ALU_AND;
            OP_EOR, OP_TEQ: r = ALU_XOR;
            OP_SUB, OP_CMP: r = ALU_MINUS;
            OP_RSB:         r = ALU_REVMINUS;
            OP_ADD, OP_CMN: r = ALU_PLUS;
            OP_ADC:         r = ALU_CPLUS;
            OP_SBC:         r = ALU_CMINUS;
            OP_RSC:         r = ALU_REVCMINUS;
            OP_ORR:         r = ALU_OR;
            OP_MOV:         r = ALU_MOVE;
            OP_BIC:         r = ALU_CLEAR;
            default:        r = ALU_NOT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the NZCV flags; cond 1111 never passes.
module cond_check
    import dp_pkg::*;
(
    input  cond_e             cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              pass_c
);

    logic n, z, v, c;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign c = flags[FLAG_C];

    always_comb begin
        pass_c = 1'b0;
        unique case (cond)
            COND_EQ: pass_c = z;
            COND_NE: pass_c = !z;
            COND_CS: pass_c = c;
            COND_CC: pass_c = !c;
            COND_MI: pass_c = n;
            COND_PL: pass_c = !n;
            COND_VS: pass_c = v;
            COND_VC: pass_c = !v;
            COND_HI: pass_c = c && !z;
            COND_LS: pass_c = !c || z;
            COND_GE: pass_c = (n == v);
            COND_LT: pass_c = (n != v);
            COND_GT: pass_c = !z && (n == v);
            COND_LE: pass_c = z || (n != v);
            COND_AL: pass_c = 1'b1;
            default: pass_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_issue.sv
// Data-processing issue unit: captures one instruction, checks its condition,
// drives the external ALU, then writes back and updates NZCV.
module dp_issue
    import dp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [DATA_W-1:0]   instr,
    input  logic [DATA_W-1:0]   rn_data,
    input  logic [DATA_W-1:0]   op2_data,
    input  logic                shift_c,
    output logic [DATA_W-1:0]   alu_src1,
    output logic [DATA_W-1:0]   alu_src2,
    output logic [3:0]          alu_ctrl,
    output logic                alu_carry,
    output logic                alu_shc,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [FLAG_W-1:0]   alu_nzvc,
    output logic                wb_en,
    output logic [REG_AW-1:0]   wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic [FLAG_W-1:0]   flags,
    output logic                done
);

    state_e              state_q, state_d;
    dp_uop_t             uop_q, uop_d;
    logic [DATA_W-1:0]   rn_q, rn_d, op2_q, op2_d;
    logic                shc_q, shc_d;
    alu_op_e             ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   src1_q, src1_d, src2_q, src2_d;
    logic                alu_shc_q, alu_shc_d;
    logic                wb_en_q, wb_en_d;
    logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                cond_pass_c;
    logic                unused_instr_bits;

    // Shift/immediate and Rn fields arrive pre-decoded on rn_data/op2_data.
    assign unused_instr_bits = ^{instr[27:25], instr[19:16], instr[11:0]};

    cond_check u_cond_check (
        .cond   (uop_q.cond),
        .flags  (flags_q),
        .pass_c (cond_pass_c)
    );

    always_comb begin
        state_d   = state_q;
        uop_d     = uop_q;
        rn_d      = rn_q;
        op2_d     = op2_q;
        shc_d     = shc_q;
        ctrl_d    = ctrl_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        alu_shc_d = alu_shc_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        ready_d   = ready_q;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    uop_d.cond = cond_e'(instr[31:28]);
                    uop_d.op   = dp_op_e'(instr[24:21]);
                    uop_d.s    = instr[20];
                    uop_d.rd   = instr[15:12];
                    rn_d       = rn_data;
                    op2_d      = op2_data;
                    shc_d      = shift_c;
                    ready_d    = 1'b0;
                    state_d    = ST_COND;
                end
            end
            ST_COND: begin
                if (cond_pass_c) begin
                    ctrl_d    = alu_map(uop_q.op);
                    // ALU NOT inverts src1, so MVN routes op2 there.
                    src1_d    = (uop_q.op == OP_MVN) ? op2_q : rn_q;
                    src2_d    = op2_q;
                    alu_shc_d = is_logical(uop_q.op) ? shc_q : 1'b0;
                    state_d   = ST_EXEC;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_SKIP;
                end
            end
            ST_EXEC: begin
                wb_en_d   = !is_compare(uop_q.op);
                wb_addr_d = uop_q.rd;
                wb_data_d = alu_result;
                done_d    = 1'b1;
                state_d   = ST_WB;
            end
            ST_WB: begin
                if (uop_q.s || is_compare(uop_q.op)) begin
                    flags_d[FLAG_N] = alu_nzvc[FLAG_N];
                    flags_d[FLAG_Z] = alu_nzvc[FLAG_Z];
                    flags_d[FLAG_C] = alu_nzvc[FLAG_C];
                    if (!is_logical(uop_q.op)) begin
                        flags_d[FLAG_V] = alu_nzvc[FLAG_V];
                    end
                end
                // Parking the ALU forces a fresh evaluation on the next opcode.
                ctrl_d  = ALU_IDLE;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_SKIP: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            uop_q     <= '0;
            rn_q      <= '0;
            op2_q     <= '0;
            shc_q     <= 1'b0;
            ctrl_q    <= ALU_IDLE;
            src1_q    <= '0;
            src2_q    <= '0;
            alu_shc_q <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            uop_q     <= uop_d;
            rn_q      <= rn_d;
            op2_q     <= op2_d;
            shc_q     <= shc_d;
            ctrl_q    <= ctrl_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            alu_shc_q <= alu_shc_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign instr_ready = ready_q;
    assign alu_src1    = src1_q;
    assign alu_src2    = src2_q;
    assign alu_ctrl    = ctrl_q;
    assign alu_carry   = flags_q[FLAG_C];
    assign alu_shc     = alu_shc_q;
    assign wb_en       = wb_en_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign flags       = flags_q;
    assign done        = done_q;

endmodule

// File: tb/tb_dp_issue.sv
// Bench for dp_issue: a table of directed instructions, a reset-in-EXEC sequence and
// random instructions checked against an ARM-level reference model.
module tb_dp_issue;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rn_data;
    logic [31:0] op2_data;
    logic        shift_c;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_ctrl;
    logic        alu_carry;
    logic        alu_shc;
    logic [31:0] alu_result = '0;
    logic [3:0]  alu_nzvc = '0;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  flags;
    logic        done;

    int checks = 0;
    int failures = 0;
    logic [3:0] mflags = 4'h0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rn;
        logic [31:0] op2;
        logic        shc;
        logic        exec;
        logic        wb;
        logic [3:0]  rd;
        logic [31:0] data;
        logic [3:0]  ctrl;
        logic [3:0]  flags;
    } vec_t;

    dp_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rn_data     (rn_data),
        .op2_data    (op2_data),
        .shift_c     (shift_c),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_ctrl    (alu_ctrl),
        .alu_carry   (alu_carry),
        .alu_shc     (alu_shc),
        .alu_result  (alu_result),
        .alu_nzvc    (alu_nzvc),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flags       (flags),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // {overflow, carry, sum}
    function automatic logic [33:0] add3(input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b} + 33'(ci);
        return {(a[31] == b[31]) && (s[31] != a[31]), s[32], s[31:0]};
    endfunction

    // Behavioural ALU that, like the real one, only recomputes on an opcode change.
    logic [3:0] alu_seen = 4'hF;
    always @(posedge clk) begin
        logic [33:0] t;
        logic        arith;
        #1;
        if (alu_ctrl !== alu_seen) begin
            alu_seen = alu_ctrl;
            arith = 1'b1;
            case (alu_ctrl)
                4'd0:  t = add3(alu_src1, alu_src2, 1'b0);
                4'd1:  t = add3(alu_src1, alu_src2, alu_carry);
                4'd2:  t = add3(alu_src1, ~alu_src2, 1'b1);
                4'd3:  t = add3(alu_src2, ~alu_src1, 1'b1);
                4'd4:  t = add3(alu_src1, ~alu_src2, alu_carry);
                4'd5:  t = add3(alu_src2, ~alu_src1, alu_carry);
                4'd6:  t = {2'b00, alu_src1 * alu_src2};
                4'd7:  begin t = {2'b00, alu_src1 & alu_src2};  arith = 1'b0; end
                4'd8:  begin t = {2'b00, alu_src1 ^ alu_src2};  arith = 1'b0; end
                4'd9:  begin t = {2'b00, alu_src1 | alu_src2};  arith = 1'b0; end
                4'd10: begin t = {2'b00, ~alu_src1};            arith = 1'b0; end
                4'd11: begin t = {2'b00, alu_src1 & ~alu_src2}; arith = 1'b0; end
                4'd12: begin t = {2'b00, alu_carry, alu_src1[31:1]}; arith = 1'b0; end
                4'd13: begin t = {2'b00, alu_src2};             arith = 1'b0; end
                default: begin t = 34'h0;                       arith = 1'b0; end
            endcase
            alu_result = t[31:0];
            alu_nzvc   = arith ? {t[31], t[31:0] == 32'h0, t[33], t[32]}
                               : {t[31], t[31:0] == 32'h0, 1'b0, alu_shc};
        end
    end

    function automatic vec_t mk(input string nm, input logic [31:0] i, input logic [31:0] r,
                                input logic [31:0] o, input logic s, input logic ex, input logic wb,
                                input logic [3:0] rd, input logic [31:0] d, input logic [3:0] ct,
                                input logic [3:0] fl);
        vec_t v;
        v.name = nm; v.instr = i; v.rn = r; v.op2 = o; v.shc = s; v.exec = ex; v.wb = wb;
        v.rd = rd; v.data = d; v.ctrl = ct; v.flags = fl;
        return v;
    endfunction

    // ARM-level reference: what the instruction does to Rd and NZCV.
    function automatic vec_t model(input logic [31:0] i, input logic [31:0] rn, input logic [31:0] op2,
                                   input logic shc, input logic [3:0] f);
        vec_t        v;
        logic        n, z, ov, c, pass, logical, compare;
        logic [3:0]  op;
        logic [33:0] t;
        n = f[3]; z = f[2]; ov = f[1]; c = f[0];
        case (i[31:28])
            4'd0:  pass = z;
            4'd1:  pass = !z;
            4'd2:  pass = c;
            4'd3:  pass = !c;
            4'd4:  pass = n;
            4'd5:  pass = !n;
            4'd6:  pass = ov;
            4'd7:  pass = !ov;
            4'd8:  pass = c && !z;
            4'd9:  pass = !c || z;
            4'd10: pass = n == ov;
            4'd11: pass = n != ov;
            4'd12: pass = !z && (n == ov);
            4'd13: pass = z || (n != ov);
            4'd14: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        op = i[24:21];
        logical = op inside {4'd0, 4'd1, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15};
        compare = op inside {4'd8, 4'd9, 4'd10, 4'd11};
        case (op)
            4'd0, 4'd8:  begin t = {2'b00, rn & op2};  v.ctrl = 4'd7;  end
            4'd1, 4'd9:  begin t = {2'b00, rn ^ op2};  v.ctrl = 4'd8;  end
            4'd2, 4'd10: begin t = add3(rn, ~op2, 1'b1); v.ctrl = 4'd2; end
            4'd3:        begin t = add3(op2, ~rn, 1'b1); v.ctrl = 4'd3; end
            4'd4, 4'd11: begin t = add3(rn, op2, 1'b0);  v.ctrl = 4'd0; end
            4'd5:        begin t = add3(rn, op2, c);     v.ctrl = 4'd1; end
            4'd6:        begin t = add3(rn, ~op2, c);    v.ctrl = 4'd4; end
            4'd7:        begin t = add3(op2, ~rn, c);    v.ctrl = 4'd5; end
            4'd12:       begin t = {2'b00, rn | op2};    v.ctrl = 4'd9; end
            4'd13:       begin t = {2'b00, op2};         v.ctrl = 4'd13; end
            4'd14:       begin t = {2'b00, rn & ~op2};   v.ctrl = 4'd11; end
            default:     begin t = {2'b00, ~op2};        v.ctrl = 4'd10; end
        endcase
        v.name = "random"; v.instr = i; v.rn = rn; v.op2 = op2; v.shc = shc;
        v.exec = pass; v.wb = !compare; v.rd = i[15:12]; v.data = t[31:0];
        if (!pass) begin
            v.ctrl = 4'hF;
            v.flags = f;
        end else if (i[20] || compare) begin
            v.flags = logical ? {t[31], t[31:0] == 32'h0, ov, shc}
                              : {t[31], t[31:0] == 32'h0, t[33], t[32]};
        end else begin
            v.flags = f;
        end
        return v;
    endfunction

    // Issue one instruction and check its full 4-cycle footprint.
    task automatic run(input vec_t v);
        int          waited;
        logic [3:0]  done_m, wbe_m, rdy_m, ctrl2, ctrl4, flags3, flags4, addr3;
        logic        carry2;
        logic [31:0] data3;
        waited = 0;
        while (!instr_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept actual=not_ready required=ready", v.name);
            return;
        end
        instr = v.instr; rn_data = v.rn; op2_data = v.op2; shift_c = v.shc; instr_valid = 1'b1;
        @(posedge clk);
        done_m = '0; wbe_m = '0; rdy_m = '0;
        ctrl2 = '0; ctrl4 = '0; flags3 = '0; flags4 = '0; addr3 = '0; carry2 = 1'b0; data3 = '0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            done_m[cyc-1] = done;
            wbe_m[cyc-1]  = wb_en;
            rdy_m[cyc-1]  = instr_ready;
            if (cyc == 1) begin
                // Offer a different instruction while busy; it must be ignored.
                instr = $urandom; rn_data = $urandom; op2_data = $urandom; shift_c = 1'($urandom);
            end else begin
                instr_valid = 1'b0;
            end
            if (cyc == 2) begin ctrl2 = alu_ctrl; carry2 = alu_carry; end
            if (cyc == 3) begin data3 = wb_data; addr3 = wb_addr; flags3 = flags; end
            if (cyc == 4) begin ctrl4 = alu_ctrl; flags4 = flags; end
        end
        check({v.name, "_done"},   32'(done_m), v.exec ? 32'h4 : 32'h2);
        check({v.name, "_wb_en"},  32'(wbe_m), (v.exec && v.wb) ? 32'h4 : 32'h0);
        check({v.name, "_ready"},  32'(rdy_m), v.exec ? 32'h8 : 32'hC);
        check({v.name, "_ctrl"},   32'(ctrl2), 32'(v.ctrl));
        check({v.name, "_idle"},   32'(ctrl4), 32'hF);
        check({v.name, "_carry"},  32'(carry2), 32'(mflags[0]));
        check({v.name, "_flg_c3"}, 32'(flags3), 32'(mflags));
        check({v.name, "_flags"},  32'(flags4), 32'(v.flags));
        if (v.exec && v.wb) begin
            check({v.name, "_wb_data"}, data3, v.data);
            check({v.name, "_wb_addr"}, 32'(addr3), 32'(v.rd));
        end
        mflags = v.flags;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t tbl[6];

    initial begin
        logic [31:0] ri;
        logic [3:0]  cnd;
        logic [3:0]  mask;
        vec_t        v;

        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; rn_data = '0; op2_data = '0; shift_c = 1'b0;
        tbl[0] = mk("adds_ovf",   32'hE0901000, 32'h7FFFFFFF, 32'd1,  1'b0, 1'b1, 1'b1, 4'd1, 32'h80000000, 4'd0,  4'b1010);
        tbl[1] = mk("cmp_eq",     32'hE1500000, 32'd5,        32'd5,  1'b0, 1'b1, 1'b0, 4'd0, 32'h0,        4'd2,  4'b0101);
        tbl[2] = mk("movne_skip", 32'h11A02000, 32'd7,        32'd9,  1'b0, 1'b0, 1'b0, 4'd2, 32'h0,        4'hF,  4'b0101);
        tbl[3] = mk("add_first",  32'hE0803000, 32'd1,        32'd2,  1'b0, 1'b1, 1'b1, 4'd3, 32'd3,        4'd0,  4'b0101);
        tbl[4] = mk("add_second", 32'hE0803000, 32'd10,       32'd20, 1'b0, 1'b1, 1'b1, 4'd3, 32'd30,       4'd0,  4'b0101);
        tbl[5] = mk("adc_carry",  32'hE0A04000, 32'd1,        32'd1,  1'b0, 1'b1, 1'b1, 4'd4, 32'd3,        4'd1,  4'b0101);

        repeat (2) @(negedge clk);
        check("rst_ctrl",  32'(alu_ctrl), 32'hF);
        check("rst_outs",  32'({instr_ready, wb_en, done, alu_shc}), 32'h8);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_data",  wb_data | alu_src1 | alu_src2 | 32'(wb_addr), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(instr_ready), 32'h1);

        foreach (tbl[k]) run(tbl[k]);

        // Reset asserted while in EXEC aborts the instruction.
        v = mk("rst_exec", 32'hE0905000, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 1'b1, 4'd5, 32'h0, 4'd0, 4'b0111);
        instr = v.instr; rn_data = v.rn; op2_data = v.op2; shift_c = 1'b0; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("rst_exec_in_exec", 32'(alu_ctrl), 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_exec_ctrl",  32'(alu_ctrl), 32'hF);
        check("rst_exec_outs",  32'({instr_ready, wb_en, done}), 32'h4);
        check("rst_exec_flags", 32'(flags), 32'h0);
        mask = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mask = mask | {2'b00, wb_en, done};
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mask = mask | {2'b00, wb_en, done};
        end
        check("rst_exec_no_strobe", 32'(mask), 32'h0);
        check("rst_exec_ready",     32'(instr_ready), 32'h1);
        check("rst_exec_flags_after", 32'(flags), 32'h0);
        mflags = 4'h0;

        for (int n = 0; n < 150; n++) begin
            cnd = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
            ri  = {cnd, 3'b000, 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 12'($urandom)};
            run(model(ri, pick_operand(), pick_operand(), 1'($urandom), mflags));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
